// File: rtl/mont_operand_seq_if.sv
// mont_operand_seq_if: start/operand inputs and mpadder control bus of the Montgomery sequencer
interface mont_operand_seq_if #(parameter int N = 512);
  logic           start;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [N-1:0]   in_m;
  logic           c_lsb;
  logic [N+1:0]   add_operand;
  logic           add_subtract;
  logic           add_enable;
  logic           add_shift;
  logic [3:0]     add_ret_sel;
  logic           acc_clear;
  logic           busy;
  logic           done;
  modport master (
    output start, in_a, in_b, in_m, c_lsb,
    input  add_operand, add_subtract, add_enable, add_shift, add_ret_sel, acc_clear, busy, done
  );
  modport slave (
    input  start, in_a, in_b, in_m, c_lsb,
    output add_operand, add_subtract, add_enable, add_shift, add_ret_sel, acc_clear, busy, done
  );
endinterface

// File: rtl/mont_operand_seq.sv
// mont_operand_seq: radix-2 Montgomery operand sequencer driving the mpadder carry-save accumulator
module mont_operand_seq #(
  parameter int N             = 512,
  parameter int RESOLVE_STEPS = 5,
  parameter int RET_IDLE      = 8
) (
  input logic               clk,
  input logic               reset,
  mont_operand_seq_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(RESOLVE_STEPS + 1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ITER = 3'd2, RESOLVE = 3'd3, DONE = 3'd4;
  logic [2:0]    state;
  logic [N-1:0]  a_sr, b, m;
  logic [N:0]    bm;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step;
  logic          a_i, q_i;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b     <= '0;
      m     <= '0;
      bm    <= '0;
      cnt   <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= LOAD;
          a_sr  <= bus.in_a;
          b     <= bus.in_b;
          m     <= bus.in_m;
        end
        LOAD: begin
          bm    <= {1'b0, b} + {1'b0, m};
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          a_sr <= a_sr >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= RESOLVE;
            step  <= '0;
          end
        end
        RESOLVE: begin
          step <= step + SW'(1);
          if (step == SW'(RESOLVE_STEPS - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // q_i uses the accumulator LSB as it will be after adding a_i*B, so the M add clears bit 0
  assign a_i = a_sr[0];
  assign q_i = bus.c_lsb ^ (a_i & b[0]);
  assign bus.add_operand  = (state != ITER) ? '0 :
                            q_i ? (a_i ? {1'b0, bm} : {2'b0, m}) :
                                  (a_i ? {2'b0, b} : '0);
  assign bus.add_subtract = 1'b0;
  assign bus.add_enable   = state == ITER;
  assign bus.add_shift    = state == ITER;
  assign bus.add_ret_sel  = (state == RESOLVE) ? 4'(step) : 4'(RET_IDLE);
  assign bus.acc_clear    = state == LOAD;
  assign bus.busy         = state != IDLE;
  assign bus.done         = state == DONE;
endmodule

// File: tb/tb_mont_operand_seq.sv
// tb_mont_operand_seq: directed checks of the sequencer against a behavioural mpadder accumulator
`timescale 1ns/1ps
module tb_mont_operand_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  mont_operand_seq_if #(.N(8))   s ();
  mont_operand_seq_if #(.N(512)) w ();
  mont_operand_seq #(.N(8))   dut8   (.clk(clk), .reset(reset), .bus(s.slave));
  mont_operand_seq #(.N(512)) dut512 (.clk(clk), .reset(reset), .bus(w.slave));
  logic [9:0]   c8;
  logic [513:0] c512;
  logic [9:0]   ops [8];
  logic [3:0]   rs [40];
  logic         en [40];
  int nops, lat;
  always #5 clk = ~clk;
  // accumulator: clear, or add operand then halve
  always @(posedge clk) begin
    if (s.acc_clear) c8 <= '0;
    else if (s.add_enable && s.add_shift) c8 <= 10'((11'(c8) + 11'(s.add_operand)) >> 1);
    if (w.acc_clear) c512 <= '0;
    else if (w.add_enable && w.add_shift) c512 <= 514'((515'(c512) + 515'(w.add_operand)) >> 1);
  end
  assign s.c_lsb = c8[0];
  assign w.c_lsb = c512[0];

  task automatic chk(input string tag, input logic [1025:0] got, input logic [1025:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    @(negedge clk);
    s.start = 1'b1; s.in_a = a; s.in_b = b; s.in_m = m;
    @(negedge clk);
    s.start = 1'b0; s.in_a = 8'($urandom); s.in_b = 8'($urandom); s.in_m = 8'($urandom);
    lat = 1; nops = 0;
    while (!s.done && lat < 40) begin
      rs[lat] = s.add_ret_sel;
      en[lat] = s.add_enable | s.add_shift;
      if (s.add_enable && nops < 8) begin ops[nops] = s.add_operand; nops++; end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 15);
    chk("ret_done", s.add_ret_sel, 8);
    chk("busy_done", s.busy, 1);
    @(negedge clk);
    chk("done_pulse", s.done, 0);
  endtask

  task automatic run512();
    logic [511:0]  a, b, m;
    logic [1025:0] lhs, rhs;
    int t;
    for (int k = 0; k < 16; k++) begin
      a[k*32 +: 32] = $urandom;
      b[k*32 +: 32] = $urandom;
      m[k*32 +: 32] = $urandom;
    end
    m[511] = 1'b1; m[0] = 1'b1;
    b = b % m;
    @(negedge clk);
    w.start = 1'b1; w.in_a = a; w.in_b = b; w.in_m = m;
    @(negedge clk);
    w.start = 1'b0; w.in_a = ~a; w.in_b = ~b; w.in_m = ~m;
    t = 1;
    while (!w.done && t < 600) begin @(negedge clk); t++; end
    chk("w_latency", t, 519);
    lhs = {c512, 512'b0} % 1026'(m);
    rhs = (1026'(a) * 1026'(b)) % 1026'(m);
    chk("w_mod", lhs, rhs);
    chk("w_lt2m", c512 < {m, 1'b0}, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp_ops [8] = '{10'h0E, 10'h0B, 10'h03, 10'h00, 10'h0B, 10'h0B, 10'h0B, 10'h00};
    int dn, t1, t2;
    s.start = 1'b0; s.in_a = '0; s.in_b = '0; s.in_m = '0;
    w.start = 1'b0; w.in_a = '0; w.in_b = '0; w.in_m = '0;
    #1;
    chk("rst_operand", s.add_operand, 0);
    chk("rst_ret_sel", s.add_ret_sel, 8);
    chk("rst_busy", s.busy, 0);
    chk("rst_done", s.done, 0);
    chk("rst_enable", s.add_enable, 0);
    @(negedge clk);
    reset = 1'b0;
    // worked example A=5 B=3 M=11
    run8(8'h05, 8'h03, 8'h0B);
    chk("ex_nops", nops, 8);
    for (int i = 0; i < 8; i++) chk("ex_op", ops[i], exp_ops[i]);
    chk("ex_result", c8, 5);
    chk("ret_load", rs[1], 8);
    chk("ret_iter_first", rs[2], 8);
    chk("ret_iter_last", rs[9], 8);
    chk("en_iter", en[2], 1);
    for (int i = 0; i < 5; i++) begin
      chk("ret_resolve", rs[10+i], i);
      chk("en_resolve", en[10+i], 0);
    end
    // A=0: only 0 or M ever selected
    run8(8'h00, 8'h03, 8'h0B);
    for (int i = 0; i < 8; i++) chk("a0_op", (ops[i] == 10'h000) || (ops[i] == 10'h00B), 1);
    chk("a0_result", c8, 0);
    // all ones: B+M needs the ninth bit
    run8(8'hFF, 8'hFF, 8'hFF);
    chk("ff_bm", ops[0], 10'h1FE);
    chk("ff_op1", ops[1], 10'h0FF);
    chk("ff_result", c8, 10'h0FF);
    // reset mid-ITER
    @(negedge clk);
    s.start = 1'b1; s.in_a = 8'h05; s.in_b = 8'h03; s.in_m = 8'h0B;
    @(negedge clk);
    s.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", s.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_operand", s.add_operand, 0);
    chk("mid_rst_enable", s.add_enable | s.add_shift, 0);
    chk("mid_rst_ret_sel", s.add_ret_sel, 8);
    chk("mid_rst_busy", s.busy, 0);
    chk("mid_rst_clear", s.acc_clear | s.done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); dn += int'(s.done); end
    chk("rst_no_done", dn, 0);
    run8(8'h05, 8'h03, 8'h0B);
    chk("post_rst_result", c8, 5);
    // start pulses during ITER and RESOLVE are ignored
    @(negedge clk);
    s.start = 1'b1; s.in_a = 8'h05; s.in_b = 8'h03; s.in_m = 8'h0B;
    dn = 0; t1 = 0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      s.start = (i == 5) || (i == 12);
      if (s.done) begin dn++; t1 = i; end
    end
    s.start = 1'b0;
    chk("poke_dones", dn, 1);
    chk("poke_time", t1, 15);
    // start held high: back-to-back runs
    @(negedge clk);
    s.start = 1'b1;
    t1 = 0; t2 = 0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (s.done && t1 == 0) t1 = i;
      else if (s.done && t2 == 0) t2 = i;
    end
    s.start = 1'b0;
    chk("held_first", t1, 15);
    chk("held_spacing", t2 - t1, 16);
    t1 = 0;
    while (s.busy && t1 < 40) begin @(negedge clk); t1++; end
    chk("held_idle", s.busy, 0);
    // N=512 random vectors
    for (int v = 0; v < 20; v++) run512();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
